// File: rtl/axi_lite_arbiter.sv
// ============================================================================
// Module   : axi_lite_arbiter
// Purpose  : Round-robin N:1 AXI-lite arbiter, one transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int GW     = $clog2(NUM_M)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M*ADDR_W-1:0]    m_araddr,
    input  logic [NUM_M-1:0]           m_arvalid,
    output logic [NUM_M-1:0]           m_arready,
    output logic [NUM_M*DATA_W-1:0]    m_rdata,
    output logic [NUM_M*2-1:0]         m_rresp,
    output logic [NUM_M-1:0]           m_rvalid,
    input  logic [NUM_M-1:0]           m_rready,
    input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
    input  logic [NUM_M-1:0]           m_awvalid,
    output logic [NUM_M-1:0]           m_awready,
    input  logic [NUM_M*DATA_W-1:0]    m_wdata,
    input  logic [NUM_M*STRB_W-1:0]    m_wstrb,
    input  logic [NUM_M-1:0]           m_wvalid,
    output logic [NUM_M-1:0]           m_wready,
    output logic [NUM_M*2-1:0]         m_bresp,
    output logic [NUM_M-1:0]           m_bvalid,
    input  logic [NUM_M-1:0]           m_bready,
    output logic [ADDR_W-1:0]          s_araddr,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    output logic [ADDR_W-1:0]          s_awaddr,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W-1:0]          s_wstrb,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    input  logic [1:0]                 s_bresp,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    output logic [GW-1:0]              grant_o,
    output logic                       busy_o
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RD_A  = 3'd1;
    localparam logic [2:0] c_RD_D  = 3'd2;
    localparam logic [2:0] c_WR_AW = 3'd3;
    localparam logic [2:0] c_WR_B  = 3'd4;

    logic [2:0]       r_state;
    logic [GW-1:0]    r_grant;
    logic [GW-1:0]    r_last;
    logic             r_aw_done;
    logic             r_w_done;

    logic [NUM_M-1:0] w_req;
    logic [GW-1:0]    w_pick;
    logic [GW-1:0]    w_cand;
    logic             w_found;
    logic             w_st_rd_a;
    logic             w_st_rd_d;
    logic             w_st_wr_aw;
    logic             w_st_wr_b;
    logic             w_aw_ok;
    logic             w_w_ok;

    // Descending scan so the closest index after r_last wins the final overwrite.
    always_comb begin
        w_req   = m_arvalid | m_awvalid;
        w_pick  = r_last;
        w_cand  = r_last;
        w_found = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            w_cand = GW'((int'(r_last) + k) % NUM_M);
            if (w_req[w_cand]) begin
                w_pick  = w_cand;
                w_found = 1'b1;
            end
        end
    end

    // Every outward valid/ready is squashed while rst is high.
    assign w_st_rd_a  = !rst && (r_state == c_RD_A);
    assign w_st_rd_d  = !rst && (r_state == c_RD_D);
    assign w_st_wr_aw = !rst && (r_state == c_WR_AW);
    assign w_st_wr_b  = !rst && (r_state == c_WR_B);

    assign s_araddr  = m_araddr[r_grant*ADDR_W +: ADDR_W];
    assign s_arvalid = w_st_rd_a & m_arvalid[r_grant];
    assign s_rready  = w_st_rd_d & m_rready[r_grant];
    assign s_awaddr  = m_awaddr[r_grant*ADDR_W +: ADDR_W];
    assign s_awvalid = w_st_wr_aw & ~r_aw_done & m_awvalid[r_grant];
    assign s_wdata   = m_wdata[r_grant*DATA_W +: DATA_W];
    assign s_wstrb   = m_wstrb[r_grant*STRB_W +: STRB_W];
    assign s_wvalid  = w_st_wr_aw & ~r_w_done & m_wvalid[r_grant];
    assign s_bready  = w_st_wr_b & m_bready[r_grant];

    assign w_aw_ok = r_aw_done | (s_awvalid & s_awready);
    assign w_w_ok  = r_w_done  | (s_wvalid & s_wready);

    assign grant_o = r_grant;
    assign busy_o  = !rst && (r_state != c_IDLE);

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (GW'(i) == r_grant) begin
                m_arready[i] = w_st_rd_a & s_arready;
                m_rvalid[i]  = w_st_rd_d & s_rvalid;
                m_awready[i] = w_st_wr_aw & ~r_aw_done & s_awready;
                m_wready[i]  = w_st_wr_aw & ~r_w_done & s_wready;
                m_bvalid[i]  = w_st_wr_b & s_bvalid;
                if (w_st_rd_d) begin
                    m_rdata[i*DATA_W +: DATA_W] = s_rdata;
                    m_rresp[i*2 +: 2]           = s_rresp;
                end
                if (w_st_wr_b) begin
                    m_bresp[i*2 +: 2] = s_bresp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_grant   <= '0;
            r_last    <= GW'(NUM_M - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        // Reads take precedence when a master raises both channels.
                        r_state <= m_arvalid[w_pick] ? c_RD_A : c_WR_AW;
                    end
                end
                c_RD_A: begin
                    if (s_arvalid && s_arready) r_state <= c_RD_D;
                end
                c_RD_D: begin
                    if (s_rvalid && s_rready) r_state <= c_IDLE;
                end
                c_WR_AW: begin
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= c_WR_B;
                    end else begin
                        r_aw_done <= w_aw_ok;
                        r_w_done  <= w_w_ok;
                    end
                end
                c_WR_B: begin
                    if (s_bvalid && s_bready) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
// ============================================================================
// Module   : tb_axi_lite_arbiter
// Purpose  : Randomized self-checking bench with a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_araddr, m_awaddr;
    logic [NM-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [NM*DW-1:0] m_rdata, m_wdata;
    logic [NM*2-1:0]  m_rresp, m_bresp;
    logic [NM*SW-1:0] m_wstrb;
    logic [AW-1:0]    s_araddr, s_awaddr;
    logic             s_arvalid, s_arready, s_rvalid, s_rready;
    logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [DW-1:0]    s_rdata, s_wdata;
    logic [1:0]       s_rresp, s_bresp;
    logic [SW-1:0]    s_wstrb;
    logic [1:0]       grant_o;
    logic             busy_o;

    axi_lite_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: last granted index plus the outstanding work per master.
    int            last_g;
    logic [NM-1:0] pend_rd, pend_wr;
    logic [AW-1:0] ar_a [NM];
    logic [AW-1:0] aw_a [NM];
    logic [DW-1:0] wd   [NM];
    logic [SW-1:0] ws   [NM];
    int            fix_aw = -1;
    int            fix_w  = -1;
    logic [SW-1:0] strb_ovr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NM-1:0] req);
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (last_g + k) % NM;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic rd_txn(input int g, input int maxw);
        int w, n;
        bit done;
        logic [DW-1:0] d, tmp;
        logic [1:0] rr;
        logic [NM-1:0] oh;
        oh = 4'b0001 << g;
        w = $urandom_range(0, maxw); n = 0; done = 0;
        while (!done && n < 60) begin
            s_arready = (n >= w);
            #1;
            check("s_arvalid", 64'(s_arvalid), 64'd1);
            check("m_arready", 64'(m_arready), s_arready ? 64'(oh) : 64'd0);
            if (s_arready) begin
                check("s_araddr", 64'(s_araddr), 64'(ar_a[g]));
                done = 1;
            end
            @(negedge clk);
            s_arready = 1'b0;
            n++;
        end
        if (!done) check("ar_timeout", 64'd0, 64'd1);
        m_arvalid[g] = 1'b0;
        pend_rd[g]   = 1'b0;
        w = $urandom_range(0, maxw); n = 0; done = 0;
        d = {$urandom, $urandom}; rr = 2'($urandom);
        while (!done && n < 60) begin
            s_rvalid = (n >= w); s_rdata = d; s_rresp = rr;
            #1;
            check("m_rvalid", 64'(m_rvalid), s_rvalid ? 64'(oh) : 64'd0);
            check("s_rready", 64'(s_rready), 64'd1);
            if (s_rvalid) begin
                check("m_rdata", m_rdata[g*DW +: DW], d);
                check("m_rresp", 64'(m_rresp[g*2 +: 2]), 64'(rr));
                for (int i = 0; i < NM; i++) begin
                    tmp = m_rdata[i*DW +: DW];
                    if (i != g) check("rdata_other", tmp, 64'd0);
                end
                done = 1;
            end
            @(negedge clk);
            s_rvalid = 1'b0;
            n++;
        end
        if (!done) check("r_timeout", 64'd0, 64'd1);
    endtask

    task automatic wr_txn(input int g, input int maxw);
        int wa, ww, n;
        bit aw_d, w_d, aw_hs, w_hs, done;
        logic [1:0] br;
        logic [NM-1:0] oh;
        oh = 4'b0001 << g;
        wa = (fix_aw >= 0) ? fix_aw : $urandom_range(0, maxw);
        ww = (fix_w  >= 0) ? fix_w  : $urandom_range(0, maxw);
        aw_d = 0; w_d = 0; n = 0;
        while (!(aw_d && w_d) && n < 60) begin
            s_awready = (n >= wa); s_wready = (n >= ww);
            #1;
            check("s_awvalid", 64'(s_awvalid), 64'(!aw_d));
            check("s_wvalid", 64'(s_wvalid), 64'(!w_d));
            check("m_awready", 64'(m_awready), (!aw_d && s_awready) ? 64'(oh) : 64'd0);
            check("m_wready", 64'(m_wready), (!w_d && s_wready) ? 64'(oh) : 64'd0);
            aw_hs = !aw_d && s_awready;
            w_hs  = !w_d && s_wready;
            if (aw_hs) check("s_awaddr", 64'(s_awaddr), 64'(aw_a[g]));
            if (w_hs) begin
                check("s_wdata", s_wdata, wd[g]);
                check("s_wstrb", 64'(s_wstrb), 64'(ws[g]));
            end
            @(negedge clk);
            s_awready = 1'b0; s_wready = 1'b0;
            if (aw_hs) begin aw_d = 1; m_awvalid[g] = 1'b0; end
            if (w_hs)  begin w_d = 1;  m_wvalid[g]  = 1'b0; end
            n++;
        end
        if (!(aw_d && w_d)) check("aw_w_timeout", 64'd0, 64'd1);
        wa = $urandom_range(0, maxw); n = 0; done = 0; br = 2'($urandom);
        while (!done && n < 60) begin
            s_bvalid = (n >= wa); s_bresp = br;
            #1;
            check("m_bvalid", 64'(m_bvalid), s_bvalid ? 64'(oh) : 64'd0);
            check("s_bready", 64'(s_bready), 64'd1);
            check("wr_b_svalid", 64'({s_awvalid, s_wvalid}), 64'd0);
            if (s_bvalid) begin
                check("m_bresp", 64'(m_bresp), 64'(br) << (g*2));
                done = 1;
            end
            @(negedge clk);
            s_bvalid = 1'b0;
            n++;
        end
        if (!done) check("b_timeout", 64'd0, 64'd1);
        pend_wr[g] = 1'b0;
    endtask

    // kinds holds 2 bits per master: 0 read, 1 write, 2/3 read and write.
    task automatic do_round(input logic [NM-1:0] mask, input logic [2*NM-1:0] kinds, input int maxw);
        int g;
        bit is_rd;
        logic [1:0] k;
        for (int i = 0; i < NM; i++) begin
            if (mask[i]) begin
                k = kinds[2*i +: 2];
                pend_rd[i] = (k != 2'd1);
                pend_wr[i] = (k != 2'd0);
                ar_a[i] = $urandom; aw_a[i] = $urandom;
                wd[i] = {$urandom, $urandom};
                ws[i] = (strb_ovr != '0) ? strb_ovr : SW'($urandom);
                m_araddr[i*AW +: AW] = ar_a[i];
                m_awaddr[i*AW +: AW] = aw_a[i];
                m_wdata[i*DW +: DW]  = wd[i];
                m_wstrb[i*SW +: SW]  = ws[i];
                m_arvalid[i] = pend_rd[i];
                m_awvalid[i] = pend_wr[i];
                m_wvalid[i]  = pend_wr[i];
            end
        end
        while ((pend_rd | pend_wr) != '0) begin
            g = pick(pend_rd | pend_wr);
            is_rd = pend_rd[g];
            last_g = g;
            #1;
            check("idle_busy", 64'(busy_o), 64'd0);
            check("idle_svalid", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd0);
            @(negedge clk);
            #1;
            check("grant", 64'(grant_o), 64'(g));
            check("busy", 64'(busy_o), 64'd1);
            if (is_rd) rd_txn(g, maxw);
            else       wr_txn(g, maxw);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        m_rready = '1; m_bready = '1;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
        pend_rd = '0; pend_wr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_sready", 64'({s_rready, s_bready}), 64'd0);
        check("rst_mvalid", 64'({m_rvalid, m_bvalid, m_arready, m_awready, m_wready}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_busy", 64'(busy_o), 64'd0);
        last_g = NM - 1;

        do_round(4'b0001, 8'h00, 2);
        do_round(4'b0011, 8'h00, 0);
        do_round(4'b0011, 8'h00, 0);
        do_round(4'b0001, 8'h02, 1);
        fix_w = 0; fix_aw = 3;
        do_round(4'b0010, 8'h04, 1);
        fix_w = -1; fix_aw = -1;
        strb_ovr = 8'hF0;
        do_round(4'b1010, 8'h44, 2);
        strb_ovr = '0;
        repeat (40) do_round(4'($urandom_range(1, 15)), 8'($urandom), 4);

        // Abandon a read in its data phase with reset.
        ar_a[2] = $urandom;
        m_araddr[2*AW +: AW] = ar_a[2];
        m_arvalid[2] = 1'b1;
        s_arready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_arvalid[2] = 1'b0;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        #1;
        check("rd_d_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_svalid", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd0);
        check("midrst_sready", 64'({s_rready, s_bready}), 64'd0);
        check("midrst_m", 64'({m_rvalid, m_bvalid, m_arready, m_awready, m_wready}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_busy", 64'(busy_o), 64'd0);
        check("after_rst_grant", 64'(grant_o), 64'd0);
        check("after_rst_mvalid", 64'({m_rvalid, m_bvalid}), 64'd0);
        last_g = NM - 1;
        do_round(4'b0011, 8'h00, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
